// File: rtl/if_id_stage_buf_if.sv
// Valid/ready bus carrying one fetched instruction and its PC between pipeline stages.
interface if_id_stage_buf_if #(
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned PC_W    = 32
);
   logic               valid;
   logic               ready;
   logic [INSTR_W-1:0] instr;
   logic [PC_W-1:0]    pc;

   modport master (output valid, output instr, output pc, input ready);
   modport slave  (input valid, input instr, input pc, output ready);
endinterface

// File: rtl/if_id_stage_buf.sv
// IF/ID stage: two-entry skid buffer with registered in_ready, flush with
// saturating drop accounting, and a NOP bubble on the output when empty.
module if_id_stage_buf #(
   parameter int unsigned        INSTR_W   = 32,
   parameter int unsigned        PC_W      = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
   parameter int unsigned        CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   if_id_stage_buf_if.slave     in_bus,
   if_id_stage_buf_if.master    out_bus,
   output logic [1:0]           occupancy,
   output logic [CNT_W-1:0]     drop_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic               h_valid, s_valid;
   logic [INSTR_W-1:0] h_instr, s_instr;
   logic [PC_W-1:0]    h_pc, s_pc;
   logic               accept, consume;
   logic               load_h_in, load_h_s, load_s;
   logic [2:0]         drop_add;
   logic [CNT_W:0]     drop_sum;

   assign h_valid   = (state != EMPTY);
   assign s_valid   = (state == TWO);
   assign occupancy = {1'b0, h_valid} + {1'b0, s_valid};

   // in_ready depends only on the state register, never on out_ready or flush.
   assign in_bus.ready  = !s_valid;
   assign out_bus.valid = h_valid;
   assign out_bus.instr = h_valid ? h_instr : NOP_INSTR;
   assign out_bus.pc    = h_valid ? h_pc : '0;

   assign accept  = in_bus.valid & in_bus.ready;
   assign consume = h_valid & out_bus.ready;

   always_comb begin
      state_nxt = state;
      load_h_in = 1'b0;
      load_h_s  = 1'b0;
      load_s    = 1'b0;
      unique case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt = ONE;
               load_h_in = 1'b1;
            end
         end
         ONE: begin
            if (accept && consume) begin
               load_h_in = 1'b1;
            end else if (accept) begin
               state_nxt = TWO;
               load_s    = 1'b1;
            end else if (consume) begin
               state_nxt = EMPTY;
            end
         end
         TWO: begin
            if (consume) begin
               state_nxt = ONE;
               load_h_s  = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      if (flush) begin
         state_nxt = EMPTY;
         load_h_in = 1'b0;
         load_h_s  = 1'b0;
         load_s    = 1'b0;
      end
   end

   // Entries lost to a flush: everything held except the one decode takes, plus any accept.
   always_comb begin
      drop_add = {1'b0, occupancy} - {2'b00, consume} + {2'b00, accept};
      drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(drop_add);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         drop_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (flush) begin
            drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_instr <= '0;
         h_pc    <= '0;
         s_instr <= '0;
         s_pc    <= '0;
      end else begin
         if (load_h_in) begin
            h_instr <= in_bus.instr;
            h_pc    <= in_bus.pc;
         end else if (load_h_s) begin
            h_instr <= s_instr;
            h_pc    <= s_pc;
         end
         if (load_s) begin
            s_instr <= in_bus.instr;
            s_pc    <= in_bus.pc;
         end
      end
   end

endmodule
